// File: rtl/core_wb_sched_pkg.sv
// core_wb_sched_pkg
// Shared types and constants for the writeback scheduler.
//   reg_num / word : register number and data word types
//   wb_src         : producer index names (0..4)
//   wb_slot        : one-entry holding slot {full, r, value}
//   N_WB_SRC       : number of result producers
//   N_WB_PORT      : number of register-file write ports
package core_wb_sched_pkg;

  typedef logic [3:0]  reg_num;
  typedef logic [31:0] word;

  localparam int N_WB_SRC  = 5;
  localparam int N_WB_PORT = 3;

  typedef enum logic [2:0] {
    WB_ALU_A  = 3'd0,
    WB_ALU_B  = 3'd1,
    WB_MUL_LO = 3'd2,
    WB_MUL_HI = 3'd3,
    WB_LDST   = 3'd4
  } wb_src;

  typedef struct packed {
    logic   full;
    reg_num r;
    word    value;
  } wb_slot;

endpackage

// File: rtl/core_wb_sched_if.sv
// core_wb_sched_if
// Bundles the producer-side handshake and the register-file write ports
// of the writeback scheduler.
//   master : execution-unit / environment side (drives src_*, observes the rest)
//   slave  : the scheduler (accepts src_*, drives ready, write ports, pending, stall)
interface core_wb_sched_if;
  import core_wb_sched_pkg::*;

  logic   [N_WB_SRC-1:0] src_valid;
  reg_num [N_WB_SRC-1:0] src_r;
  word    [N_WB_SRC-1:0] src_value;
  logic   [N_WB_SRC-1:0] src_ready;

  logic   wr_enable_a, wr_enable_b, wr_enable_c;
  reg_num wr_r_a,      wr_r_b,      wr_r_c;
  word    wr_value_a,  wr_value_b,  wr_value_c;

  logic [15:0] pending;
  logic        wb_stall;

  modport master (
    output src_valid, src_r, src_value,
    input  src_ready,
    input  wr_enable_a, wr_enable_b, wr_enable_c,
    input  wr_r_a, wr_r_b, wr_r_c,
    input  wr_value_a, wr_value_b, wr_value_c,
    input  pending, wb_stall
  );

  modport slave (
    input  src_valid, src_r, src_value,
    output src_ready,
    output wr_enable_a, wr_enable_b, wr_enable_c,
    output wr_r_a, wr_r_b, wr_r_c,
    output wr_value_a, wr_value_b, wr_value_c,
    output pending, wb_stall
  );

endinterface

// File: rtl/core_wb_sched_rr_pick.sv
// core_wb_rr_pick
// Combinational rotating scan. Starting at rr_ptr and wrapping mod N_SRC,
// the first up to N_PORT requesters are assigned to ports 0, 1, 2 in scan
// order. req_hi requesters are all placed before any req_lo requester.
//   rr_ptr      : scan start index
//   req_hi      : high-rank request mask (held slots)
//   req_lo      : low-rank request mask (bypass offers; zero when unused)
//   sel         : per-port one-hot source select
//   port_vld    : per-port grant-present bits
//   rr_ptr_next : (last granted index + 1) mod N_SRC, or rr_ptr if no grant
module core_wb_rr_pick #(
  parameter int N_SRC  = 5,
  parameter int N_PORT = 3,
  localparam int PTR_W = $clog2(N_SRC)
) (
  input  logic [PTR_W-1:0]                rr_ptr,
  input  logic [N_SRC-1:0]                req_hi,
  input  logic [N_SRC-1:0]                req_lo,
  output logic [N_PORT-1:0][N_SRC-1:0]    sel,
  output logic [N_PORT-1:0]               port_vld,
  output logic [PTR_W-1:0]                rr_ptr_next
);

  always_comb begin
    int cnt;
    int idx;
    int last;
    // NOTE: every output and temporary gets a default before the loops;
    // otherwise paths that assign nothing would infer latches.
    sel         = '0;
    port_vld    = '0;
    rr_ptr_next = rr_ptr;
    cnt         = 0;
    idx         = 0;
    last        = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < N_SRC; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_SRC) idx = idx - N_SRC;
        if (cnt < N_PORT && ((pass == 0) ? req_hi[idx] : req_lo[idx])) begin
          sel[cnt][idx] = 1'b1;
          port_vld[cnt] = 1'b1;
          last          = idx;
          cnt           = cnt + 1;
        end
      end
    end
    if (cnt != 0) rr_ptr_next = PTR_W'((last == N_SRC - 1) ? 0 : last + 1);
  end

endmodule

// File: rtl/core_wb_sched.sv
// core_wb_sched
// Writeback scheduler: five result producers (alu_a, alu_b, mul_lo, mul_hi,
// ldst) each own a one-entry slot; a rotating round-robin maps up to three
// full slots per cycle onto register-file write ports a/b/c.
//   clk, rst_n : core clock, asynchronous active-low reset
//   wb (slave) : src_valid/src_r/src_value in, src_ready out,
//                wr_enable/wr_r/wr_value a/b/c out, pending[15:0], wb_stall
// Optional build macro CORE_WB_BYPASS_EN: an offer to an empty slot joins
// the same-cycle scan (ranked after held slots) and, if it wins a port, is
// written directly without ever occupying its slot.
module core_wb_sched
  import core_wb_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  core_wb_sched_if.slave  wb
);

  localparam int N_SRC  = N_WB_SRC;
  localparam int N_PORT = N_WB_PORT;
  localparam int PTR_W  = $clog2(N_SRC);

  wb_slot [N_SRC-1:0]             slot_q, slot_d;
  logic   [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;

  logic   [N_SRC-1:0]             full;
  logic   [N_SRC-1:0]             byp_req;
  logic   [N_SRC-1:0]             grant;
  logic   [N_SRC-1:0]             byp_grant;
  logic   [N_SRC-1:0]             ready;
  logic   [N_SRC-1:0]             accept;
  logic   [N_PORT-1:0][N_SRC-1:0] sel;
  logic   [N_PORT-1:0]            port_vld;
  reg_num [N_PORT-1:0]            port_r;
  word    [N_PORT-1:0]            port_value;
  logic   [15:0]                  pending;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) full[i] = slot_q[i].full;
  end

`ifdef CORE_WB_BYPASS_EN
  assign byp_req = wb.src_valid & ~full;
`else
  assign byp_req = '0;
`endif

  core_wb_rr_pick #(
    .N_SRC  (N_SRC),
    .N_PORT (N_PORT)
  ) u_pick (
    .rr_ptr      (rr_ptr_q),
    .req_hi      (full),
    .req_lo      (byp_req),
    .sel         (sel),
    .port_vld    (port_vld),
    .rr_ptr_next (rr_ptr_d)
  );

  // A selected source is either a held slot or (bypass only) a live offer.
  always_comb begin
    grant     = '0;
    byp_grant = '0;
    for (int p = 0; p < N_PORT; p++) begin
      grant     = grant     | (sel[p] &  full);
      byp_grant = byp_grant | (sel[p] & ~full);
    end
  end

  // Ready depends on slot flops and rr_ptr only, never on src_valid.
  assign ready  = ~full | grant;
  assign accept = wb.src_valid & ready;

  always_comb begin
    slot_d = slot_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (accept[i] && !byp_grant[i]) begin
        slot_d[i].full  = 1'b1;
        slot_d[i].r     = wb.src_r[i];
        slot_d[i].value = wb.src_value[i];
      end else if (grant[i]) begin
        slot_d[i].full = 1'b0;
      end
    end
  end

  always_comb begin
    port_r     = '0;
    port_value = '0;
    for (int p = 0; p < N_PORT; p++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (sel[p][i]) begin
          port_r[p]     = full[i] ? slot_q[i].r     : wb.src_r[i];
          port_value[p] = full[i] ? slot_q[i].value : wb.src_value[i];
        end
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (full[i]) pending[slot_q[i].r] = 1'b1;
    end
  end

  // NOTE: the slot array is a handful of flops rather than a RAM, so it is
  // reset wholesale; only the full bits matter, data is cleared for tidiness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      slot_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      slot_q   <= slot_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign wb.src_ready   = ready;
  assign wb.pending     = pending;
  assign wb.wb_stall    = |(full & ~grant);

  assign wb.wr_enable_a = port_vld[0];
  assign wb.wr_enable_b = port_vld[1];
  assign wb.wr_enable_c = port_vld[2];
  assign wb.wr_r_a      = port_r[0];
  assign wb.wr_r_b      = port_r[1];
  assign wb.wr_r_c      = port_r[2];
  assign wb.wr_value_a  = port_value[0];
  assign wb.wr_value_b  = port_value[1];
  assign wb.wr_value_c  = port_value[2];

`ifndef SYNTHESIS
  // Dispatch never has two in-flight writes to one register; flag it if so.
  logic dup_r;
  always_comb begin
    dup_r = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      for (int j = i + 1; j < N_SRC; j++) begin
        if (full[i] && full[j] && slot_q[i].r == slot_q[j].r) dup_r = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!dup_r);
  end
`endif

endmodule

// File: tb/tb_core_wb_sched.sv
// tb_core_wb_sched
// Directed bench for core_wb_sched. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Expected values
// assume the default build except where the bypass step is guarded.
module tb_core_wb_sched;
  import core_wb_sched_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  core_wb_sched_if wb ();

  core_wb_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    wb.src_valid = '0;
    wb.src_r     = '0;
    wb.src_value = '0;
  endtask

  task automatic offer(input int i, input reg_num r, input word v);
    wb.src_valid[i] = 1'b1;
    wb.src_r[i]     = r;
    wb.src_value[i] = v;
  endtask

  initial begin
    idle();

    // Reset state
    #2;
    check("rst_en_a",  32'(wb.wr_enable_a), 32'd0);
    check("rst_en_b",  32'(wb.wr_enable_b), 32'd0);
    check("rst_en_c",  32'(wb.wr_enable_c), 32'd0);
    check("rst_pend",  32'(wb.pending),     32'd0);
    check("rst_stall", 32'(wb.wb_stall),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(wb.src_ready),   32'h1f);
    check("rel_rr",    32'(dut.rr_ptr_q),   32'd0);

    // Five simultaneous offers r1..r5 from rr_ptr = 0
    tick();
    for (int i = 0; i < 5; i++) offer(i, reg_num'(i + 1), word'(32'hA1 + i));
    sample();
    check("five_ready0", 32'(wb.src_ready), 32'h1f);
    tick();
    idle();
    sample();
    check("five_c1_en",    {29'd0, wb.wr_enable_a, wb.wr_enable_b, wb.wr_enable_c}, 32'd7);
    check("five_c1_ra",    32'(wb.wr_r_a),     32'd1);
    check("five_c1_rb",    32'(wb.wr_r_b),     32'd2);
    check("five_c1_rc",    32'(wb.wr_r_c),     32'd3);
    check("five_c1_vc",    wb.wr_value_c,      32'hA3);
    check("five_c1_stall", 32'(wb.wb_stall),   32'd1);
    check("five_c1_pend",  32'(wb.pending),    32'h003E);
    check("five_c1_ready", 32'(wb.src_ready),  32'h07);
    tick();
    sample();
    check("five_c2_rr",    32'(dut.rr_ptr_q),  32'd3);
    check("five_c2_en",    {29'd0, wb.wr_enable_a, wb.wr_enable_b, wb.wr_enable_c}, 32'd6);
    check("five_c2_ra",    32'(wb.wr_r_a),     32'd4);
    check("five_c2_rb",    32'(wb.wr_r_b),     32'd5);
    check("five_c2_vb",    wb.wr_value_b,      32'hA5);
    check("five_c2_stall", 32'(wb.wb_stall),   32'd0);
    check("five_c2_pend",  32'(wb.pending),    32'h0030);
    tick();
    sample();
    check("five_c3_pend",  32'(wb.pending),    32'd0);
    check("five_c3_rr",    32'(dut.rr_ptr_q),  32'd0);

    // Wrap-around: advance rr_ptr to 3, then fill slots 0, 1, 4
    tick();
    for (int i = 0; i < 3; i++) offer(i, reg_num'(8 + i), word'(32'hB0 + i));
    tick();
    idle();
    tick();
    offer(0, 4'd11, 32'hC0);
    offer(1, 4'd12, 32'hC1);
    offer(4, 4'd13, 32'hC4);
    sample();
    check("wrap_rr3", 32'(dut.rr_ptr_q), 32'd3);
    tick();
    idle();
    sample();
    check("wrap_en",  {29'd0, wb.wr_enable_a, wb.wr_enable_b, wb.wr_enable_c}, 32'd7);
    check("wrap_ra",  32'(wb.wr_r_a), 32'd13);
    check("wrap_rb",  32'(wb.wr_r_b), 32'd11);
    check("wrap_rc",  32'(wb.wr_r_c), 32'd12);
    check("wrap_va",  wb.wr_value_a,  32'hC4);
    tick();
    sample();
    check("wrap_rr2", 32'(dut.rr_ptr_q), 32'd2);

    // Single write: alu_a r3 = 0xDEADBEEF
    tick();
    offer(0, 4'd3, 32'hDEADBEEF);
    sample();
    check("single_ready", 32'(wb.src_ready[0]), 32'd1);
    check("single_pend0", 32'(wb.pending),      32'd0);
    tick();
    idle();
    sample();
    check("single_en_a",  32'(wb.wr_enable_a),  32'd1);
    check("single_r_a",   32'(wb.wr_r_a),       32'd3);
    check("single_v_a",   wb.wr_value_a,        32'hDEADBEEF);
    check("single_pend",  32'(wb.pending),      32'h0008);
    check("single_stall", 32'(wb.wb_stall),     32'd0);
    tick();
    sample();
    check("single_en_off", 32'(wb.wr_enable_a), 32'd0);
    check("single_pend_c", 32'(wb.pending),     32'd0);
    check("single_rr",     32'(dut.rr_ptr_q),   32'd1);

    // Streaming: mul_lo offers for 8 consecutive cycles
    for (int k = 0; k <= 8; k++) begin
      tick();
      idle();
      if (k < 8) offer(2, 4'd6, word'(32'h100 + k));
      sample();
      if (k < 8) check($sformatf("stream_ready%0d", k), 32'(wb.src_ready[2]), 32'd1);
      if (k > 0) begin
        check($sformatf("stream_en%0d", k),  32'(wb.wr_enable_a), 32'd1);
        check($sformatf("stream_val%0d", k), wb.wr_value_a, word'(32'h100 + k - 1));
      end
    end
    tick();
    sample();
    check("stream_done_en", 32'(wb.wr_enable_a), 32'd0);

    // Bypass step: ldst r7 = 0x12 into an empty slot
    tick();
    offer(4, 4'd7, 32'h12);
    sample();
`ifdef CORE_WB_BYPASS_EN
    check("byp_en_now",  32'(wb.wr_enable_a), 32'd1);
    check("byp_r_now",   32'(wb.wr_r_a),      32'd7);
    check("byp_v_now",   wb.wr_value_a,       32'h12);
    check("byp_pend_now", 32'(wb.pending),    32'd0);
`else
    check("nobyp_en_now", 32'(wb.wr_enable_a), 32'd0);
    check("nobyp_pend_now", 32'(wb.pending),   32'd0);
`endif
    tick();
    idle();
    sample();
`ifdef CORE_WB_BYPASS_EN
    check("byp_en_next",   32'(wb.wr_enable_a), 32'd0);
    check("byp_pend_next", 32'(wb.pending),     32'd0);
`else
    check("nobyp_en_next",   32'(wb.wr_enable_a), 32'd1);
    check("nobyp_r_next",    32'(wb.wr_r_a),      32'd7);
    check("nobyp_v_next",    wb.wr_value_a,       32'h12);
    check("nobyp_pend_next", 32'(wb.pending),     32'h0080);
`endif
    tick();
    sample();
    check("byp_pend_clear", 32'(wb.pending), 32'd0);

    // Reset mid-operation with three slots full
    tick();
    for (int i = 0; i < 3; i++) offer(i, reg_num'(1 + i), word'(32'hE0 + i));
    tick();
    idle();
    #1;
    check("mid_busy_en_a", 32'(wb.wr_enable_a), 32'd1);
    check("mid_busy_pend", 32'(wb.pending),     32'h000E);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en",   {29'd0, wb.wr_enable_a, wb.wr_enable_b, wb.wr_enable_c}, 32'd0);
    check("mid_rst_pend", 32'(wb.pending),  32'd0);
    check("mid_rst_stall", 32'(wb.wb_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 32'(wb.src_ready), 32'h1f);
    tick();
    sample();
    check("mid_rel_en",   {29'd0, wb.wr_enable_a, wb.wr_enable_b, wb.wr_enable_c}, 32'd0);
    check("mid_rel_pend", 32'(wb.pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_wb_sched.md
Name: core_wb_sched

Overview:
- Writeback scheduler that shares the three register-file write ports (a/b/c) among five result producers: alu_a, alu_b, mul_lo, mul_hi and ldst.
- Each producer has a one-entry holding slot. A rotating round-robin grant maps up to three full slots per cycle onto the write ports.
- Sits between the execution units (ALUs, multiplier, load/store control) and core_regs.
- Exports a per-register pending mask for dispatch hazard checks, plus a stall signal.

Parameters:
- N_SRC, 5, number of result producers; index 0..4 = alu_a, alu_b, mul_lo, mul_hi, ldst.
- N_PORT, 3, number of register-file write ports; fixed 3 in this core, range 1..N_SRC.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- src_valid  in  N_SRC  producer i offers a write this cycle
- src_r  in  N_SRC x reg_num  destination register per producer
- src_value  in  N_SRC x word  result value per producer
- src_ready  out  N_SRC  producer i's offer is accepted this cycle
- wr_enable_a/b/c  out  1  write-port enables to core_regs
- wr_r_a/b/c  out  reg_num  write-port register numbers
- wr_value_a/b/c  out  word  write-port data
- pending  out  16  bit r set while any slot holds a write to register r
- wb_stall  out  1  at least one full slot was not granted this cycle

Behaviour:
- Reset (asynchronous, rst_n low):
  - all slots empty; rr_ptr = 0.
  - wr_enable_* = 0; pending = 0; wb_stall = 0.
  - src_ready = 1 for all sources once reset is released.
- Reset mid-operation: all held writes are discarded and none reach the ports.
- Slot i (full, r, value) is a flop.
  - Accept condition: src_valid[i] && src_ready[i]. On accept, the slot loads src_r[i]/src_value[i] at the next edge.
  - src_ready[i] = !full[i] || grant[i].
  - grant depends only on slot flops and rr_ptr, so there is no combinational path from valid to ready.
- Grant:
  - Scan sources in rotation order rr_ptr, rr_ptr+1, ... mod N_SRC.
  - The first up to N_PORT full slots are granted. The k-th granted slot drives port k (a, b, c).
  - Ports with no grant have wr_enable = 0; their wr_r/wr_value are don't-care and are driven 0.
- A granted slot empties at the next edge unless it is refilled by a same-cycle accept. Back-to-back throughput is one write per source per cycle.
- rr_ptr update:
  - If any grant occurred, rr_ptr becomes (index of last granted source + 1) mod N_SRC.
  - Otherwise rr_ptr holds.
  - Wrap-around from 4 to 0 is required.
- Latency: two edges from src_valid to the register-file write. The slot loads at the first edge; the write is presented during the following cycle and committed at the second edge.
- pending[r] = OR over full slots with slot.r == r.
  - It reflects slot state only, not the current cycle's src_valid.
  - It clears in the cycle after the grant, unless the slot was refilled.
- wb_stall = OR over i of (full[i] && !grant[i]).
- Same-register conflict: dispatch guarantees no two in-flight writes to the same register.
  - A simulation-only assertion fires if two full slots hold equal r.
  - Two equal-r grants would both be issued in that case. No ordering is promised.
- All slots full, no new valid: grants issue 3 then 2 over two cycles. src_ready stays 0 for ungranted full slots.

Optional Feature:
- Macro: CORE_WB_BYPASS_EN.
- Defined:
  - When slot i is empty and src_valid[i] is high, the offer joins the same-cycle grant scan as if its slot were full.
  - If it receives a port, it is written directly and the slot stays empty. Latency is one edge.
  - Bypass candidates rank after full slots, so held writes are drained first.
  - This adds a valid-to-wr_enable combinational path. src_ready remains independent of src_valid.
- Undefined: no bypass; latency is always two edges.

Decomposition:
- Shared package (core/uarch.sv):
  - wb_src enum (WB_ALU_A, WB_ALU_B, WB_MUL_LO, WB_MUL_HI, WB_LDST).
  - constants N_WB_SRC = 5 and N_WB_PORT = 3.
  - wb_slot struct {full, reg_num r, word value}.
  - the existing reg_num/word typedefs.
- Sub-module core_wb_rr_pick: combinational rotation scan.
  - Inputs: request mask, rr_ptr.
  - Outputs: per-port one-hot select, port-valid bits, and next rr_ptr.
- Slot registers, pending/stall logic and the port muxes stay in core_wb_sched.

Test Plan:
- Reset: hold rst_n low mid-traffic with 3 slots full → all wr_enable 0 and pending 0 immediately (asynchronous). After release, src_ready = 5'b11111 and no writes are issued.
- Single write: alu_a offers r3 = 0xDEADBEEF → wr_enable_a = 1, wr_r_a = 3, wr_value_a = 0xDEADBEEF in the cycle after accept. pending[3] is high for exactly that cycle. rr_ptr becomes 1.
- Five simultaneous offers (r1..r5) from rr_ptr = 0:
  - cycle 1: ports a/b/c get r1/r2/r3; wb_stall = 1; rr_ptr becomes 3.
  - cycle 2: ports a/b get r4/r5; wb_stall = 0.
- Wrap-around: rr_ptr = 3 with slots 0, 1, 4 full → port order a = ldst, b = alu_a, c = alu_b; next rr_ptr = 2.
- Streaming: mul_lo offers every cycle for 8 cycles → src_ready stays 1 throughout. Eight consecutive writes occur with in-order values.
- CORE_WB_BYPASS_EN defined, slots empty, ldst offers r7 = 0x12 → wr_enable_a = 1 in the same cycle, slot stays empty, pending[7] never sets. Undefined build → write appears one cycle later.
